// File: rtl/imem_fetch_controller.sv
// Instruction memory sequencer: streams a boot image into the memory, then owns the PC
// and fills the IF/ID register, honouring stall, redirect and out-of-range halt.
module imem_fetch_controller #(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic [31:0] imem_addr,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        halted,
  output logic [10:0] load_count
);

  localparam int unsigned   PW        = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] LAST_WORD = PW'(DEPTH - 1);
  localparam logic [31:0]   PC_LIMIT  = 32'(DEPTH * 4);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   ifid_instr_q, ifid_instr_d;
  logic [31:0]   ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic          ifid_valid_q, ifid_valid_d;
  logic          flush_ifid;
  logic [31:0]   redirect_aligned;

  // Misaligned redirect targets are accepted and rounded down to the word.
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d         = state_q;
    pc_d            = pc_q;
    wr_ptr_d        = wr_ptr_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    flush_ifid      = 1'b0;
    load_ready      = 1'b0;
    imem_we         = 1'b0;
    imem_addr       = '0;
    imem_wdata      = '0;

    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
        end else begin
          state_d    = S_RUN;
          pc_d       = RESET_PC;
          flush_ifid = 1'b1;
        end
      end

      S_LOAD: begin
        load_ready = (wr_ptr_q < DEPTH_CNT);
        imem_addr  = 32'({wr_ptr_q, 2'b00});
        imem_wdata = load_data;
        imem_we    = load_valid & load_ready;
        if (imem_we) wr_ptr_d = wr_ptr_q + PW'(1);
        // A word offered on the cycle load_en drops is still written before leaving.
        if (!load_en || (imem_we && (wr_ptr_q == LAST_WORD))) begin
          state_d    = S_RUN;
          pc_d       = RESET_PC;
          flush_ifid = 1'b1;
        end
      end

      S_RUN: begin
        imem_addr = pc_q;
        if (load_en) begin
          state_d    = S_LOAD;
          wr_ptr_d   = '0;
          flush_ifid = 1'b1;
        end else if (redirect) begin
          pc_d         = redirect_aligned;
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
        end else if (pc_q >= PC_LIMIT) begin
          state_d      = S_HALT;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          ifid_instr_d    = imem_rdata;
          ifid_pc_plus4_d = pc_q + 32'd4;
          ifid_valid_d    = 1'b1;
          pc_d            = pc_q + 32'd4;
        end
      end

      S_HALT: begin
        imem_addr = pc_q;
        if (load_en) begin
          state_d    = S_LOAD;
          wr_ptr_d   = '0;
          flush_ifid = 1'b1;
        end else if (redirect) begin
          state_d = S_RUN;
          pc_d    = redirect_aligned;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (flush_ifid) begin
      ifid_valid_d    = 1'b0;
      ifid_instr_d    = '0;
      ifid_pc_plus4_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC;
      wr_ptr_q        <= '0;
      ifid_instr_q    <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      wr_ptr_q        <= wr_ptr_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

  assign pc            = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign halted        = (state_q == S_HALT);
  assign load_count    = 11'(wr_ptr_q);

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Scoreboard bench for imem_fetch_controller: a behavioural model predicts every cycle's
// observable outputs and every memory write; a negedge monitor pops and compares.
module tb_imem_fetch_controller;

  localparam int          DEPTH    = 1024;
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_LIMIT = 32'(DEPTH * 4);

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_HALT = 3;

  logic        clk, rst_n;
  logic        load_en, load_valid, load_ready;
  logic [31:0] load_data;
  logic [31:0] imem_addr, imem_wdata, imem_rdata;
  logic        imem_we;
  logic        stall, redirect;
  logic [31:0] redirect_pc, pc, ifid_instr, ifid_pc_plus4;
  logic        ifid_valid, halted;
  logic [10:0] load_count;

  imem_fetch_controller #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
    .halted(halted), .load_count(load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical instruction memory: written by the DUT, read combinationally.
  logic [31:0] mem [DEPTH];
  assign imem_rdata = mem[imem_addr[AW+1:2]];
  always @(posedge clk) if (imem_we) mem[imem_addr[AW+1:2]] <= imem_wdata;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic [31:0] addr;
    logic        iv;
    logic        halted;
    logic        ready;
    logic        we;
    logic [10:0] cnt;
  } snap_t;

  snap_t       sb_q[$];
  logic [63:0] wr_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: what the program image should be and where the fetcher is.
  int          m_mode;
  int          m_cnt;
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_iv;
  logic [31:0] ref_mem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    snap_t       e;
    logic [63:0] w;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("pc", pc, e.pc);
      check("ifid_valid", 32'(ifid_valid), 32'(e.iv));
      check("ifid_instr", ifid_instr, e.instr);
      check("ifid_pc_plus4", ifid_pc_plus4, e.p4);
      check("halted", 32'(halted), 32'(e.halted));
      check("load_ready", 32'(load_ready), 32'(e.ready));
      check("imem_we", 32'(imem_we), 32'(e.we));
      check("imem_addr", imem_addr, e.addr);
      check("load_count", 32'(load_count), 32'(e.cnt));
    end
    if (imem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", imem_addr, w[63:32]);
        check("wr_data", imem_wdata, w[31:0]);
      end
    end
  end

  task automatic clear_ifid();
    m_iv    = 1'b0;
    m_instr = '0;
    m_p4    = '0;
  endtask

  // Drive one cycle of inputs, record the expected view of this cycle, then step the model.
  task automatic cycle(input logic rst, input logic le, input logic lv, input logic [31:0] ld,
                       input logic st, input logic rd, input logic [31:0] rpc);
    snap_t e;
    rst_n = rst; load_en = le; load_valid = lv; load_data = ld;
    stall = st; redirect = rd; redirect_pc = rpc;
    if (!rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_pc = RESET_PC;
      clear_ifid();
    end
    e.pc     = m_pc;
    e.instr  = m_instr;
    e.p4     = m_p4;
    e.iv     = m_iv;
    e.halted = (m_mode == M_HALT);
    e.ready  = (m_mode == M_LOAD) && (m_cnt < DEPTH);
    e.we     = e.ready && lv;
    e.addr   = (m_mode == M_LOAD) ? 32'(m_cnt * 4) :
               (m_mode == M_RUN || m_mode == M_HALT) ? m_pc : 32'h0;
    e.cnt    = 11'(m_cnt);
    sb_q.push_back(e);
    if (rst) begin
      case (m_mode)
        M_IDLE: begin
          if (le) begin m_mode = M_LOAD; m_cnt = 0; end
          else begin m_mode = M_RUN; m_pc = RESET_PC; clear_ifid(); end
        end
        M_LOAD: begin
          if (e.we) begin
            ref_mem[m_cnt] = ld;
            wr_q.push_back({32'(m_cnt * 4), ld});
            m_cnt++;
          end
          if (!le || m_cnt == DEPTH) begin m_mode = M_RUN; m_pc = RESET_PC; clear_ifid(); end
        end
        M_RUN: begin
          if (le) begin m_mode = M_LOAD; m_cnt = 0; clear_ifid(); end
          else if (rd) begin m_pc = rpc & ~32'h3; m_iv = 1'b0; m_instr = '0; end
          else if (m_pc >= PC_LIMIT) begin m_mode = M_HALT; m_iv = 1'b0; end
          else if (!st) begin
            m_instr = ref_mem[m_pc / 4];
            m_p4    = m_pc + 32'd4;
            m_iv    = 1'b1;
            m_pc    = m_pc + 32'd4;
          end
        end
        default: begin
          if (le) begin m_mode = M_LOAD; m_cnt = 0; clear_ifid(); end
          else if (rd) begin m_mode = M_RUN; m_pc = rpc & ~32'h3; end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  logic [31:0] prog [5] = '{32'h02128020, 32'h02129022, 32'h02729820, 32'h0272a022, 32'h0292a020};

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    rst_n = 1'b0; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(posedge clk);
    #1;

    // Reset values, then boot load of the five-word program with random gaps.
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'hdead_beef, 1'b1, 1'b1, 32'h44);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      while ($urandom_range(0, 2) == 0) cycle(1'b1, 1'b1, 1'b0, $urandom, 1'b0, 1'b0, 32'h0);
      // The last word arrives on the same cycle load_en drops.
      cycle(1'b1, (i != 4), 1'b1, prog[i], 1'b0, 1'b0, 32'h0);
    end

    // Fetch to pc=8, stall three cycles, then resume.
    quiet(2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    quiet(5);

    // Misaligned redirect together with stall.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0012);
    quiet(3);

    // Random stall/redirect/short-load traffic, including redirects past the memory end.
    for (int i = 0; i < 400; i++) begin
      cycle(1'b1, ($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            $urandom_range(0, DEPTH * 4 + 32));
    end

    // Full-depth load with load_valid always high and load_en never dropped by the writer.
    quiet(2);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);

    // Sequential fetch runs off the end, halts, then a redirect to 0 resumes.
    quiet(DEPTH + 2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, $urandom_range(0, 1), 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    quiet(3);

    // Reset in the middle of a load; the three words written survive.
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    quiet(5);

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    check("writes_drained", 32'(wr_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_controller.md
Name: imem_fetch_controller

Overview:
- Sequences the word-addressed 4 KB instruction memory.
- Boot phase: streams a program image into the memory through its write port.
- Run phase: owns the PC, issues fetch addresses and captures the IF/ID pipeline register.
- Handles pipeline stall, branch/jump redirect and out-of-range fetch halt; sits between the instruction memory and the decode stage.

Parameters:
- DEPTH, 1024, instruction memory depth in 32-bit words (power of two).
- RESET_PC, 32'h00000000, PC loaded on entry to RUN (word aligned).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_en  input  1  request/hold program-load mode
- load_valid  input  1  load_data valid
- load_data  input  32  instruction word to write
- load_ready  output  1  controller accepts a load word this cycle
- imem_addr  output  32  byte address to instruction memory (memory indexes addr>>2)
- imem_we  output  1  instruction memory write enable
- imem_wdata  output  32  instruction memory write data
- imem_rdata  input  32  combinational read data for imem_addr
- stall  input  1  hold PC and IF/ID (hazard unit)
- redirect  input  1  taken branch/jump; load redirect_pc
- redirect_pc  input  32  redirect target byte address
- pc  output  32  current fetch PC
- ifid_instr  output  32  IF/ID instruction
- ifid_pc_plus4  output  32  IF/ID PC+4
- ifid_valid  output  1  IF/ID holds a real instruction
- halted  output  1  high in HALT state
- load_count  output  11  words written in the current/last load

Behaviour:
States: IDLE, LOAD, RUN, HALT. All state is asynchronously reset by rst_n low.

Reset values:
- State IDLE, pc=RESET_PC, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0, load_count=0.
- Outputs: imem_we=0, load_ready=0, halted=0, imem_addr=0.

IDLE (one cycle after reset release):
- load_en=1 -> LOAD with wr_ptr=0 and load_count=0.
- Otherwise -> RUN.

LOAD:
- load_ready = (wr_ptr < DEPTH).
- imem_addr = wr_ptr<<2, imem_wdata = load_data, imem_we = load_valid & load_ready.
- Each accepted word: wr_ptr++, load_count++.
- Exit to RUN when load_en falls, or on the cycle the DEPTH-th word is accepted.
- If load_valid and load_en fall in the same cycle, the word is still written.
- On LOAD->RUN: pc=RESET_PC, IF/ID cleared (ifid_valid=0).

RUN:
- imem_we=0, load_ready=0, imem_addr=pc (combinational).
- Per cycle, priority order: redirect > stall > normal fetch.
- redirect:
  - pc <= {redirect_pc[31:2],2'b00}; low two bits are silently forced to zero.
  - ifid_valid <= 0, ifid_instr <= 0.
  - Applies even when stall is high; the wrong-path fetch is flushed.
- stall (no redirect): pc, ifid_* hold.
- normal fetch:
  - ifid_instr <= imem_rdata, ifid_pc_plus4 <= pc+4, ifid_valid <= 1, pc <= pc+4.
  - 32-bit PC arithmetic wraps modulo 2^32.
- Fetch latency: an instruction at pc appears on ifid_* the clock edge after pc is presented.
- Out-of-range fetch: when pc >= DEPTH*4 and no redirect is present:
  - Go to HALT; no capture, ifid_valid <= 0, pc holds.
- load_en=1 in RUN: -> LOAD next cycle; IF/ID flushed; wr_ptr and load_count reset to 0.
- load_en takes priority over redirect and stall.

HALT:
- halted=1, imem_we=0, ifid_valid=0, pc holds.
- load_en=1 -> LOAD.
- Else redirect=1 -> RUN with pc=aligned redirect_pc.
- stall is ignored.

Reset mid-operation:
- rst_n low at any time returns immediately to the reset values.
- A partial load is abandoned; already-written memory words are not cleared.

Instruction 32'h00000000 is a valid NOP and is captured with ifid_valid=1.

Test Plan:
1. Reset, load_en=1, stream 5 words 02128020, 02129022, 02729820, 0272a022, 0292a020, then drop load_en:
   - imem_we pulses at addresses 0, 4, 8, 12, 16; load_count=5.
   - Then RUN with pc=0; ifid_instr sequence matches the 5 words; ifid_pc_plus4 = 4, 8, 12, 16, 20.
2. RUN at pc=8, assert stall for 3 cycles:
   - pc stays 8 and ifid_* hold for 3 cycles; fetch of 0x08 is captured the cycle after stall drops.
3. RUN, redirect=1 with redirect_pc=0x00000012 together with stall=1:
   - Next cycle pc=0x10, ifid_valid=0.
   - Following cycle ifid_instr=IM[4], ifid_pc_plus4=0x14.
4. Load with load_valid held high and load_en never dropped (DEPTH=1024):
   - Exactly 1024 writes occur; load_ready low after the 1024th.
   - Auto-transition to RUN; load_count=1024.
5. Sequential fetch reaches pc=0x1000 (DEPTH=1024):
   - halted=1, ifid_valid=0, pc=0x1000.
   - redirect to 0x0 returns to RUN and fetches IM[0].
6. Assert rst_n low during LOAD after 3 words:
   - Outputs immediately at reset values.
   - After release with load_en=0, controller enters RUN at pc=0, and the 3 written words are fetched.
